// File: rtl/shift_sequencer.sv
// Multi-cycle left shifter: shifts a captured operand by up to STEP_MAX bits per
// cycle and reports the result plus zero/negative/carry-out/overflow flags.
module shift_sequencer #(
  parameter int unsigned STEP_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand,
  input  logic [4:0]  amount,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zeroFlag,
  output logic        negativeFlag,
  output logic        carryoutFlag,
  output logic        overflowFlag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  rem_q, rem_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;
  logic        msb_q;
  logic [4:0]  step;
  logic [4:0]  carry_idx;

  logic        busy_q, done_q;
  logic [31:0] result_q;
  logic        zero_q, neg_q, cout_q, ovfl_q;

  // One shift step; a zero step (amount == 0) leaves every datapath register untouched.
  always_comb begin
    step      = (rem_q > 5'(STEP_MAX)) ? 5'(STEP_MAX) : rem_q;
    rem_d     = rem_q - step;
    carry_idx = 5'd31 - (step - 5'd1);
    acc_d     = acc_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    if (step != 5'd0) begin
      acc_d   = acc_q << step;
      carry_d = acc_q[carry_idx];
      ovf_d   = ovf_q | (acc_d[31] != msb_q);
      for (int i = 0; i < 3; i++) begin
        if ((5'(i) < step) && (acc_q[5'(31 - i)] != msb_q)) ovf_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset clears datapath and outputs alike, since a
  // freshly reset block must present all-zero result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      msb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      cout_q   <= 1'b0;
      ovfl_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q   <= operand;
            rem_q   <= amount;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            msb_q   <= operand[31];
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= acc_d;
          rem_q   <= rem_d;
          carry_q <= carry_d;
          ovf_q   <= ovf_d;
          if (rem_d == 5'd0) begin
            done_q   <= 1'b1;
            result_q <= acc_d;
            zero_q   <= (acc_d == 32'd0);
            neg_q    <= acc_d[31];
            cout_q   <= carry_d;
            ovfl_q   <= ovf_d;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign zeroFlag     = zero_q;
  assign negativeFlag = neg_q;
  assign carryoutFlag = cout_q;
  assign overflowFlag = ovfl_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, flags and timing
// for STEP_MAX = 3, plus start-ignore, back-to-back and mid-operation reset.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] operand;
  logic [4:0]  amount;
  logic        busy, done;
  logic [31:0] result;
  logic        zeroFlag, negativeFlag, carryoutFlag, overflowFlag;

  int vectors = 0;
  int miscompares = 0;

  shift_sequencer #(.STEP_MAX(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .operand      (operand),
    .amount       (amount),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .zeroFlag     (zeroFlag),
    .negativeFlag (negativeFlag),
    .carryoutFlag (carryoutFlag),
    .overflowFlag (overflowFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    logic [4:0]  amt;
    int          k;
    logic [35:0] exp;   // {result, zero, negative, carryout, overflow}
  } vec_t;

  // Starts one operation and follows it until busy drops; the walk is bounded.
  task automatic do_op(input logic [31:0] op, input logic [4:0] amt,
                       output int nbusy, output int done_at, output int ndone);
    @(negedge clk);
    operand = op;
    amount  = amt;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nbusy = 0; done_at = -1; ndone = 0;
    for (int c = 0; c < 50; c++) begin
      if (!busy) break;
      nbusy++;
      if (done) begin
        ndone++;
        done_at = nbusy;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; operand = '0; amount = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag} !== 38'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b%b%b%b, want all 0",
               busy, done, result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vectors();
    vec_t tbl[8];
    int nb, da, nd;
    tbl[0] = '{32'hF0F0F0F0, 5'd4,  2,  {32'h0F0F0F00, 4'b0011}};
    tbl[1] = '{32'h80000000, 5'd0,  1,  {32'h80000000, 4'b0100}};
    tbl[2] = '{32'h80000000, 5'd1,  1,  {32'h00000000, 4'b1011}};
    tbl[3] = '{32'h00000001, 5'd31, 11, {32'h80000000, 4'b0101}};
    tbl[4] = '{32'h40000000, 5'd1,  1,  {32'h80000000, 4'b0101}};
    tbl[5] = '{32'h00000003, 5'd3,  1,  {32'h00000018, 4'b0000}};
    tbl[6] = '{32'hFFFFFFFF, 5'd5,  2,  {32'hFFFFFFE0, 4'b0110}};
    tbl[7] = '{32'h12345678, 5'd6,  2,  {32'h8D159E00, 4'b0101}};
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].amt, nb, da, nd);
      vectors++;
      if (nb !== tbl[i].k + 1 || da !== tbl[i].k + 1 || nd !== 1) begin
        miscompares++;
        $display("FAIL timing[%0d]: got busy_cycles=%0d done_at=%0d done_pulses=%0d, want %0d/%0d/1",
                 i, nb, da, nd, tbl[i].k + 1, tbl[i].k + 1);
      end
      vectors++;
      if ({result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag} !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL result[%0d]: got %h zncv=%b%b%b%b, want %h zncv=%b",
                 i, result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag,
                 tbl[i].exp[35:4], tbl[i].exp[3:0]);
      end
    end
  endtask

  task automatic test_hold();
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag} !==
        {2'b00, 32'h8D159E00, 4'b0101}) begin
      miscompares++;
      $display("FAIL idle_hold: got busy=%b done=%b result=%h, want 0 0 8d159e00 zncv=0101",
               busy, done, result);
    end
  endtask

  task automatic test_start_ignored();
    int nb = 0;
    int nd = 0;
    @(negedge clk);
    operand = 32'h00000001; amount = 5'd31; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    operand = 32'hFFFFFFFF; amount = 5'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (!busy) break;
      nb++;
      if (done) nd++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (nd !== 1 || result !== 32'h80000000 || {negativeFlag, overflowFlag} !== 2'b11) begin
      miscompares++;
      $display("FAIL start_ignored: got done_pulses=%0d result=%h n=%b v=%b, want 1 80000000 1 1",
               nd, result, negativeFlag, overflowFlag);
    end
    // Only 3 busy samples elapse before the stray start; the rest of the 12 follow.
    vectors++;
    if (nb !== 9) begin
      miscompares++;
      $display("FAIL start_ignored_len: got busy_after_pulse=%0d, want 9", nb);
    end
  endtask

  task automatic test_back_to_back();
    int nb, da, nd;
    do_op(32'h00000003, 5'd3, nb, da, nd);
    // do_op drives start before the very first IDLE edge after the previous op.
    do_op(32'hF0F0F0F0, 5'd4, nb, da, nd);
    vectors++;
    if (nb !== 3 || nd !== 1 || result !== 32'h0F0F0F00) begin
      miscompares++;
      $display("FAIL back_to_back: got busy_cycles=%0d done_pulses=%0d result=%h, want 3 1 0f0f0f00",
               nb, nd, result);
    end
  endtask

  task automatic test_reset_abort();
    int nd = 0;
    int nb, da, nd2;
    @(negedge clk);
    operand = 32'h00000001; amount = 5'd31; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag} !== 38'd0) begin
      miscompares++;
      $display("FAIL reset_abort: got busy=%b done=%b result=%h flags=%b%b%b%b, want all 0",
               busy, done, result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    vectors++;
    if (nd !== 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d busy/done cycles after abort, want 0", nd);
    end
    do_op(32'h80000000, 5'd1, nb, da, nd2);
    vectors++;
    if (nb !== 2 || da !== 2 || nd2 !== 1 ||
        {result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag} !== {32'h0, 4'b1011}) begin
      miscompares++;
      $display("FAIL after_reset: got busy=%0d done_at=%0d pulses=%0d result=%h zncv=%b%b%b%b, want 2 2 1 0 1011",
               nb, da, nd2, result, zeroFlag, negativeFlag, carryoutFlag, overflowFlag);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
